reg_dump_reader: RTL and testbench

Debug/readback sequencer on the read side of the 16x8 register file. On a start request it stalls the core and steps the register file read address from first_reg to last_reg inclusive, wrapping modulo 2**regAddressWidth. It captures each combinational read result and streams {address, data} beats over a valid/ready interface to the debug/UART path. It pulses done after the last accepted beat.

---
 rtl/reg_dump_reader.sv | 87 ++++++++
 tb/tb_reg_dump_reader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - register file readback sequencer streaming {addr, data} beats
module reg_dump_reader #(
  parameter int regAddressWidth = 4,
  parameter int regDataWidth    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [regAddressWidth-1:0] first_reg,
  input  logic [regAddressWidth-1:0] last_reg,
  input  logic [regDataWidth-1:0]    read_data,
  output logic [regAddressWidth-1:0] read_register,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [regAddressWidth-1:0] dump_addr,
  output logic [regDataWidth-1:0]    dump_data,
  output logic                       stall,
  output logic                       busy,
  output logic                       done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [regAddressWidth:0]   COUNT_ONE = 1;
  localparam logic [regAddressWidth-1:0] PTR_ONE   = 1;

  logic [1:0]                 state;
  logic [regAddressWidth-1:0] ptr;
  // One extra bit so a full wrap (16 beats) is representable.
  logic [regAddressWidth:0]   count;

  assign read_register = ptr;
  assign stall         = (state != IDLE);
  assign busy          = stall;
  assign done          = (state == FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      count      <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else if (abort) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr   <= first_reg;
            count <= {1'b0, last_reg - first_reg} + COUNT_ONE;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          // Capture one cycle after stall rose so the core's final write has landed.
          dump_data  <= read_data;
          dump_addr  <= ptr;
          dump_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (count == COUNT_ONE) begin
              state <= FINISH;
            end else begin
              ptr   <= ptr + PTR_ONE;
              count <= count - COUNT_ONE;
              state <= SETTLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - scoreboard bench for reg_dump_reader
module tb_reg_dump_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] first_reg;
  logic [3:0] last_reg;
  logic [7:0] read_data;
  logic [3:0] read_register;
  logic       dump_valid;
  logic       dump_ready;
  logic [3:0] dump_addr;
  logic [7:0] dump_data;
  logic       stall;
  logic       busy;
  logic       done;

  logic [7:0]  regs [16];
  logic [11:0] sb [$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;
  bit prev_hs = 1'b0;

  always #5 clk = ~clk;

  assign read_data = regs[read_register];

  reg_dump_reader #(.regAddressWidth(4), .regDataWidth(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg), .read_data(read_data),
    .read_register(read_register), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .stall(stall), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        check("done_with_stall", {31'd0, stall}, 32'd1);
      end
      if (dump_valid && dump_ready) begin
        check("beat_expected", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) check("beat", {20'd0, dump_addr, dump_data}, {20'd0, sb.pop_front()});
        check("no_back_to_back", {31'd0, prev_hs}, 32'd0);
      end
      prev_hs = dump_valid && dump_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] f, input logic [3:0] l);
    logic [3:0] a;
    a = f;
    forever begin
      sb.push_back({a, regs[a]});
      if (a == l) break;
      a = a + 4'd1;
    end
    exp_done++;
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    check({tag, "_beats_left"}, sb.size(), 32'd0);
    check({tag, "_done_count"}, done_cnt, exp_done);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h10 + 8'(i);
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    first_reg = '0; last_reg = '0; dump_ready = 1'b1;
    tick(); tick();
    check("rst_valid", {31'd0, dump_valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rreg", {28'd0, read_register}, 32'd0);
    check("rst_addr_data", {20'd0, dump_addr, dump_data}, 32'd0);
    reset = 1'b0;
    tick();

    // Full 0..15 dump with latency checks.
    do_start(4'd0, 4'd15);
    check("t1_stall_after_start", {31'd0, stall}, 32'd1);
    check("t1_valid_one_edge", {31'd0, dump_valid}, 32'd0);
    tick();
    check("t1_valid_two_edges", {31'd0, dump_valid}, 32'd1);
    check("t1_first_addr", {28'd0, dump_addr}, 32'd0);
    wait_idle("t1");
    check("t1_stall_after", {31'd0, stall}, 32'd0);

    // Wrap-around and single beat.
    do_start(4'd14, 4'd1);
    wait_idle("t2a");
    do_start(4'd5, 4'd5);
    wait_idle("t2b");

    // Full 16-beat wrap with a different data pattern.
    for (int i = 0; i < 16; i++) regs[i] = 8'hA0 ^ 8'(i * 7);
    do_start(4'd6, 4'd5);
    wait_idle("t3");

    // Backpressure on beat 0.
    dump_ready = 1'b0;
    do_start(4'd2, 4'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_valid_held", {31'd0, dump_valid}, 32'd1);
      check("t4_addr_held", {28'd0, dump_addr}, 32'd2);
      check("t4_data_held", {24'd0, dump_data}, {24'd0, regs[2]});
      tick();
    end
    dump_ready = 1'b1;
    wait_idle("t4");

    // Start during SEND is ignored.
    do_start(4'd0, 4'd3);
    tick();
    first_reg = 4'd8; last_reg = 4'd9; start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    wait_idle("t5a");

    // Abort during second beat.
    do_start(4'd0, 4'd15);
    begin
      int n;
      n = 0;
      while (!(dump_valid && dump_addr == 4'd1) && n < 50) begin
        tick();
        n++;
      end
      check("t5_reach_beat1", {31'd0, dump_valid && dump_addr == 4'd1}, 32'd1);
    end
    dump_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    dump_ready = 1'b1;
    check("t5_abort_valid", {31'd0, dump_valid}, 32'd0);
    check("t5_abort_stall", {31'd0, stall}, 32'd0);
    sb.delete();
    exp_done--;
    tick(); tick();
    check("t5_abort_no_done", done_cnt, exp_done);
    do_start(4'd3, 4'd4);
    wait_idle("t5b");

    // Asynchronous reset mid-SEND.
    do_start(4'd0, 4'd15);
    tick(); tick(); tick();
    check("t6_in_send", {31'd0, dump_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid", {31'd0, dump_valid}, 32'd0);
    check("t6_stall", {31'd0, stall}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_rreg", {28'd0, read_register}, 32'd0);
    check("t6_addr_data", {20'd0, dump_addr, dump_data}, 32'd0);
    sb.delete();
    exp_done--;
    tick();
    reset = 1'b0;
    tick();
    do_start(4'd9, 4'd11);
    wait_idle("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
